fp_gpio_ctrl_v2: RTL and testbench

Parametrised front-panel GPIO controller, successor to the fixed-mask FP GPIO block. It adds runtime-programmable DDR and in/out masks via the settings bus, and a configurable-depth input synchronizer. Each pin gets a programmable-length debounce filter, plus sticky rising/falling edge capture with an interrupt output and a readback mux. It sits between the FP GPIO pads (fp_gpio_*) and the radio core GPIO/settings interface.

---
 rtl/fp_gpio_ctrl_v2_if.sv | 18 +
 rtl/fp_gpio_ctrl_v2.sv | 157 +++++++++++++++
 tb/tb_fp_gpio_ctrl_v2.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_gpio_ctrl_v2_if.sv
// Settings-bus write port and readback port of the FP GPIO controller.
interface fp_gpio_ctrl_v2_if;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [2:0]  rb_addr;
    logic [31:0] rb_data;

    modport master (
        output set_stb, set_addr, set_data, rb_addr,
        input  rb_data
    );

    modport slave (
        input  set_stb, set_addr, set_data, rb_addr,
        output rb_data
    );
endinterface

// File: rtl/fp_gpio_ctrl_v2.sv
// Front-panel GPIO controller: runtime masks/DDR, synchronizer, per-pin
// debounce, sticky edge capture with interrupt, and registered readback.
module fp_gpio_ctrl_v2 #(
    parameter int               WIDTH         = 12,
    parameter int               SYNC_STAGES   = 2,
    parameter int               CNT_W         = 10,
    parameter logic [7:0]       SR_BASE       = 8'd0,
    parameter logic [WIDTH-1:0] OUT_MASK_INIT = 12'h011,
    parameter logic [WIDTH-1:0] IN_MASK_INIT  = 12'h044,
    parameter logic [WIDTH-1:0] DDR_INIT      = 12'h011,
    parameter int               DEB_INIT      = 10
) (
    input  logic             clk,
    input  logic             reset,
    fp_gpio_ctrl_v2_if.slave bus,
    input  logic [WIDTH-1:0] i_fp_gpio_in,
    output logic [WIDTH-1:0] o_fp_gpio_out,
    output logic [WIDTH-1:0] o_fp_gpio_ddr,
    input  logic [WIDTH-1:0] i_gpio_out,
    output logic [WIDTH-1:0] o_gpio_in,
    output logic             o_irq
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_ddr;
    logic [WIDTH-1:0] r_out_mask;
    logic [WIDTH-1:0] r_in_mask;
    logic [CNT_W-1:0] r_deb;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_fout;
    logic             r_irq;

    logic [7:0]       w_wr;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_adopt;
    logic [WIDTH-1:0] w_rise_set;
    logic [WIDTH-1:0] w_fall_set;
    logic             w_short;
    logic [CNT_W-1:0] w_lenm1;
    logic [31:0]      w_rb;
    logic             w_unused;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_data   = bus.set_data[WIDTH-1:0];
    assign w_clr    = w_wr[4] ? w_data : '0;
    assign w_short  = (r_deb <= CNT_W'(1));
    assign w_lenm1  = r_deb - CNT_W'(1);
    assign w_unused = ^bus.set_data;

    assign o_gpio_in     = r_stable & r_in_mask;
    assign o_fp_gpio_ddr = r_ddr;
    assign o_fp_gpio_out = r_fout;
    assign o_irq         = r_irq;

    always_comb begin
        w_wr = '0;
        for (int k = 0; k < 8; k++) begin
            w_wr[k] = bus.set_stb && (bus.set_addr == 8'(SR_BASE + 8'(k)));
        end
    end

    // A pin adopts the synced value once it has differed for deb_len cycles.
    always_comb begin
        w_adopt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_adopt[i] = (w_s[i] != r_stable[i]) &&
                         (w_short || (r_cnt[i] >= w_lenm1));
        end
    end

    assign w_rise_set = w_adopt & w_s;
    assign w_fall_set = w_adopt & ~w_s;

    always_comb begin
        w_rb = '0;
        case (bus.rb_addr)
            3'd0:    w_rb = 32'(r_stable);
            3'd1:    w_rb = 32'(r_rise);
            3'd2:    w_rb = 32'(r_fall);
            3'd3:    w_rb = 32'(r_ddr);
            3'd4:    w_rb = 32'(r_out_mask);
            3'd5:    w_rb = 32'(r_in_mask);
            3'd6:    w_rb = 32'(r_deb);
            default: w_rb = (32'(r_rise_en) << 16) | 32'(r_fall_en);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= i_fp_gpio_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_s[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_adopt[i]) begin
                    r_stable[i] <= w_s[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ddr       <= DDR_INIT;
            r_out_mask  <= OUT_MASK_INIT;
            r_in_mask   <= IN_MASK_INIT;
            r_deb       <= CNT_W'(DEB_INIT);
            r_rise_en   <= '0;
            r_fall_en   <= '0;
            r_rise      <= '0;
            r_fall      <= '0;
            r_fout      <= '0;
            r_irq       <= 1'b0;
            bus.rb_data <= '0;
        end else begin
            if (w_wr[0]) r_ddr      <= w_data;
            if (w_wr[1]) r_out_mask <= w_data;
            if (w_wr[2]) r_in_mask  <= w_data;
            if (w_wr[3]) r_deb      <= bus.set_data[CNT_W-1:0];
            if (w_wr[5]) r_rise_en  <= w_data;
            if (w_wr[6]) r_fall_en  <= w_data;
            // A new edge in the same cycle as a clear keeps its bit.
            r_rise      <= (r_rise & ~w_clr) | w_rise_set;
            r_fall      <= (r_fall & ~w_clr) | w_fall_set;
            r_fout      <= i_gpio_out & r_out_mask;
            r_irq       <= (|(r_rise & r_rise_en)) | (|(r_fall & r_fall_en));
            bus.rb_data <= w_rb;
        end
    end

endmodule

// File: tb/tb_fp_gpio_ctrl_v2.sv
// Scoreboard bench for fp_gpio_ctrl_v2: directed scenarios then random
// traffic, checked every cycle against a run-length reference model.
module tb_fp_gpio_ctrl_v2;

    localparam int W    = 12;
    localparam int SYNC = 2;

    typedef struct {
        logic [W-1:0] gin;
        logic [W-1:0] fout;
        logic [W-1:0] ddr;
        logic         irq;
        logic [31:0]  rb;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pad = '0;
    logic [W-1:0] gout = '0;
    logic [W-1:0] fout, ddr, gin;
    logic         irq;

    fp_gpio_ctrl_v2_if bus();

    fp_gpio_ctrl_v2 dut (
        .clk           (clk),
        .reset         (rst),
        .bus           (bus),
        .i_fp_gpio_in  (pad),
        .o_fp_gpio_out (fout),
        .o_fp_gpio_ddr (ddr),
        .i_gpio_out    (gout),
        .o_gpio_in     (gin),
        .o_irq         (irq)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    // Reference model state
    logic [W-1:0] m_ddr, m_om, m_im, m_re, m_fe, m_rise, m_fall, m_stable;
    logic [W-1:0] m_fout;
    logic [W-1:0] hist [SYNC];
    int           run [W];
    int           m_deb;
    logic         m_irq;
    logic [31:0]  m_rb;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        logic [W-1:0] s, rs, fs, clr, d;
        int           k, lim;
        if (rst) begin
            m_ddr = 12'h011; m_om = 12'h011; m_im = 12'h044; m_deb = 10;
            m_re = '0; m_fe = '0; m_rise = '0; m_fall = '0; m_stable = '0;
            m_fout = '0; m_irq = 1'b0; m_rb = '0;
            for (int j = 0; j < SYNC; j++) hist[j] = '0;
            for (int i = 0; i < W; i++) run[i] = 0;
            return;
        end
        case (bus.rb_addr)
            3'd0: m_rb = 32'(m_stable);
            3'd1: m_rb = 32'(m_rise);
            3'd2: m_rb = 32'(m_fall);
            3'd3: m_rb = 32'(m_ddr);
            3'd4: m_rb = 32'(m_om);
            3'd5: m_rb = 32'(m_im);
            3'd6: m_rb = 32'(m_deb);
            default: m_rb = 32'(m_re) * 65536 + 32'(m_fe);
        endcase
        m_irq  = ((m_rise & m_re) != 0) || ((m_fall & m_fe) != 0);
        m_fout = gout & m_om;
        s = hist[SYNC-1];
        for (int j = SYNC - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = pad;
        lim = (m_deb < 1) ? 1 : m_deb;
        rs = '0; fs = '0;
        for (int i = 0; i < W; i++) begin
            if (s[i] != m_stable[i]) begin
                run[i]++;
                if (run[i] >= lim) begin
                    m_stable[i] = s[i];
                    if (s[i]) rs[i] = 1'b1; else fs[i] = 1'b1;
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        k   = bus.set_stb ? int'(bus.set_addr) : -1;
        d   = bus.set_data[W-1:0];
        clr = (k == 4) ? d : '0;
        m_rise = (m_rise & ~clr) | rs;
        m_fall = (m_fall & ~clr) | fs;
        case (k)
            0: m_ddr = d;
            1: m_om  = d;
            2: m_im  = d;
            3: m_deb = int'(bus.set_data[9:0]);
            5: m_re  = d;
            6: m_fe  = d;
            default: ;
        endcase
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        model_step();
        e.gin  = m_stable & m_im;
        e.fout = m_fout;
        e.ddr  = m_ddr;
        e.irq  = m_irq;
        e.rb   = m_rb;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic wr(input int k, input logic [31:0] d);
        bus.set_stb  = 1'b1;
        bus.set_addr = 8'(k);
        bus.set_data = d;
        cyc();
        bus.set_stb  = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_gpio_in",  32'(gin),  32'(e.gin));
            chk("sb_fp_out",   32'(fout), 32'(e.fout));
            chk("sb_fp_ddr",   32'(ddr),  32'(e.ddr));
            chk("sb_irq",      32'(irq),  32'(e.irq));
            chk("sb_rb_data",  bus.rb_data, e.rb);
        end
    end

    initial begin
        bus.set_stb = 1'b0; bus.set_addr = '0; bus.set_data = '0;
        bus.rb_addr = 3'd0;
        repeat (2) cyc();
        rst = 1'b0;

        bus.rb_addr = 3'd3; cyc();
        chk("rst_rb_ddr", bus.rb_data, 32'h011);
        chk("rst_fp_ddr", 32'(ddr), 32'h011);
        bus.rb_addr = 3'd6; cyc();
        chk("rst_rb_deb", bus.rb_data, 32'd10);
        chk("rst_gpio_in", 32'(gin), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);

        gout = 12'hFFF; cyc();
        chk("out_init_mask", 32'(fout), 32'h011);
        wr(1, 32'h0F0); cyc();
        chk("out_new_mask", 32'(fout), 32'h0F0);

        pad[2] = 1'b1;
        repeat (11) cyc();
        chk("deb_before_12", 32'(gin), 32'h000);
        cyc();
        chk("deb_at_12", 32'(gin), 32'h004);

        bus.rb_addr = 3'd1;
        pad[6] = 1'b1; repeat (9) cyc();
        pad[6] = 1'b0; repeat (20) cyc();
        chk("glitch_gin", 32'(gin), 32'h004);
        chk("glitch_rise", bus.rb_data, 32'h004);
        pad[2] = 1'b0; repeat (14) cyc();

        wr(3, 0);
        pad[2] = 1'b1; cyc(); cyc();
        chk("deb0_before", 32'(gin), 32'h000);
        cyc();
        chk("deb0_at_3", 32'(gin), 32'h004);
        pad[2] = 1'b0; repeat (3) cyc();
        chk("deb0_fall", 32'(gin), 32'h000);

        wr(4, 32'hFFF); wr(5, 32'h004); wr(3, 10);
        pad[2] = 1'b1; repeat (20) cyc();
        pad[2] = 1'b0; repeat (20) cyc();
        chk("edge_rise", bus.rb_data, 32'h004);
        bus.rb_addr = 3'd2; cyc();
        chk("edge_fall", bus.rb_data, 32'h004);
        chk("edge_irq", 32'(irq), 32'h1);
        bus.rb_addr = 3'd1;
        wr(4, 32'h004); cyc();
        chk("clr_rise", bus.rb_data, 32'h000);
        chk("clr_irq", 32'(irq), 32'h0);

        wr(3, 0);
        pad[2] = 1'b1; cyc(); cyc();
        wr(4, 32'h004); cyc();
        chk("clr_vs_set", bus.rb_data, 32'h004);
        pad[2] = 1'b0; repeat (4) cyc();

        wr(3, 100);
        pad[0] = 1'b1; repeat (50) cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        bus.rb_addr = 3'd0;
        chk("mid_rst_rb", bus.rb_data, 32'h0);
        wr(3, 100); repeat (60) cyc();
        chk("mid_rst_hold", bus.rb_data, 32'h0);
        repeat (50) cyc();
        chk("mid_rst_stable", bus.rb_data, 32'h001);
        bus.rb_addr = 3'd1; cyc();
        chk("mid_rst_rise", bus.rb_data, 32'h001);

        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 7) == 0) pad[i] = ~pad[i];
            if ($urandom_range(0, 15) == 0) gout = W'($urandom);
            bus.rb_addr = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 5) == 0) begin
                bus.set_stb  = 1'b1;
                bus.set_addr = 8'($urandom_range(0, 9));
                bus.set_data = (bus.set_addr == 8'd3) ?
                               32'($urandom_range(0, 6)) : $urandom;
            end else begin
                bus.set_stb = 1'b0;
            end
            cyc();
        end
        rst = 1'b0; bus.set_stb = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
